// File: rtl/oc8051_ext_int_ctrl.sv
// External-interrupt controller for the 8051 FPGA top.
// Synchronises active-low interrupt pins, detects edges/levels per source,
// arbitrates by two-level priority and issues one vectored request at a time
// to the core with a req/ack handshake. Tracks in-service nesting until RETI.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   int_n             : raw interrupt pins (active-low, asynchronous)
//   cfg_en/pri/edge   : per-source enable, priority (1=high), edge mode (1=falling edge)
//   glob_en           : global enable (EA)
//   int_ack, reti     : one-cycle pulses from the core
//   int_req           : vectored request to the core
//   int_src, int_vec  : requesting source index and its vector address
//   int_act           : any interrupt in service
//   in_svc            : in-service flags {high, low}
module oc8051_ext_int_ctrl #(
    parameter int unsigned NUM_SRC  = 3,
    parameter logic [7:0]  VEC_BASE = 8'h03,
    parameter logic [7:0]  VEC_STEP = 8'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_n,
    input  logic [NUM_SRC-1:0] cfg_en,
    input  logic [NUM_SRC-1:0] cfg_pri,
    input  logic [NUM_SRC-1:0] cfg_edge,
    input  logic               glob_en,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [2:0]         int_src,
    output logic [7:0]         int_vec,
    output logic               int_act,
    output logic [1:0]         in_svc
);

    localparam int unsigned SRC_W = 3;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               win_pri_q, win_pri_d;
    logic               req_d;
    logic [SRC_W-1:0]   src_d;
    logic [7:0]         vec_d;
    logic [1:0]         svc_d;

    logic [NUM_SRC-1:0] eligible;
    logic               hi_ok, lo_ok;
    logic               win_found, win_hi;
    logic [SRC_W-1:0]   win_idx;
    logic               src_elig;
    logic               ack_hit;

    function automatic logic [7:0] vec_of(input logic [SRC_W-1:0] idx);
        return VEC_BASE + 8'(8'(idx) * VEC_STEP);
    endfunction

    // Two-flop synchroniser plus delay flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= int_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Priority arbitration: high beats low, lowest index wins within a level.
    // High sources may preempt anything but a high in service; low only when idle.
    always_comb begin
        eligible  = pending_q & cfg_en & {NUM_SRC{glob_en}};
        hi_ok     = ~in_svc[1];
        lo_ok     = ~in_svc[1] & ~in_svc[0];
        win_found = 1'b0;
        win_hi    = 1'b0;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i] && !cfg_pri[i] && lo_ok) begin
                win_found = 1'b1;
                win_hi    = 1'b0;
                win_idx   = SRC_W'(i);
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i] && cfg_pri[i] && hi_ok) begin
                win_found = 1'b1;
                win_hi    = 1'b1;
                win_idx   = SRC_W'(i);
            end
        end
        src_elig = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int_src == SRC_W'(i)) src_elig = eligible[i];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            win_pri_q <= 1'b0;
            int_req   <= 1'b0;
            int_src   <= '0;
            int_vec   <= 8'h00;
            in_svc    <= 2'b00;
            int_act   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            win_pri_q <= win_pri_d;
            int_req   <= req_d;
            int_src   <= src_d;
            int_vec   <= vec_d;
            in_svc    <= svc_d;
            int_act   <= |svc_d;
        end
    end

    // Next-state, handshake, nesting and pending update
    always_comb begin
        state_d   = state_q;
        req_d     = int_req;
        src_d     = int_src;
        vec_d     = int_vec;
        win_pri_d = win_pri_q;
        ack_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    src_d     = win_idx;
                    vec_d     = vec_of(win_idx);
                    win_pri_d = win_hi;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous withdraw
                if (int_ack) begin
                    ack_hit = 1'b1;
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (!src_elig) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // RETI clears on pre-cycle state, then a same-cycle ack sets its bit
        svc_d = in_svc;
        if (reti) begin
            if (in_svc[1])      svc_d[1] = 1'b0;
            else if (in_svc[0]) svc_d[0] = 1'b0;
        end
        if (ack_hit) begin
            if (win_pri_q) svc_d[1] = 1'b1;
            else           svc_d[0] = 1'b1;
        end

        // Edge: set on fall (wins over ack clear). Level: follow the pin.
        pending_d = pending_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_edge[i]) begin
                pending_d[i] = (s3[i] & ~s2[i]) |
                               (pending_q[i] & ~(ack_hit && (int_src == SRC_W'(i))));
            end else begin
                pending_d[i] = ~s2[i];
            end
        end
    end

endmodule

// File: tb/tb_oc8051_ext_int_ctrl.sv
// Randomised bench for oc8051_ext_int_ctrl against a cycle-level behavioural model.
module tb_oc8051_ext_int_ctrl;

    localparam int unsigned NS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] int_n, cfg_en, cfg_pri, cfg_edge;
    logic          glob_en, int_ack, reti;
    logic          int_req, int_act;
    logic [2:0]    int_src;
    logic [7:0]    int_vec;
    logic [1:0]    in_svc;

    oc8051_ext_int_ctrl #(.NUM_SRC(NS), .VEC_BASE(8'h03), .VEC_STEP(8'h08)) dut (
        .clk(clk), .rst(rst), .int_n(int_n), .cfg_en(cfg_en), .cfg_pri(cfg_pri),
        .cfg_edge(cfg_edge), .glob_en(glob_en), .int_ack(int_ack), .reti(reti),
        .int_req(int_req), .int_src(int_src), .int_vec(int_vec),
        .int_act(int_act), .in_svc(in_svc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Model state: pin samples from the last three edges, pending, nesting, request
    logic [NS-1:0] hist0, hist1, hist2;
    logic [NS-1:0] m_pend;
    logic [1:0]    m_svc;
    bit            m_busy, m_pri;
    int            m_src;

    task automatic model_reset();
        hist0 = '1; hist1 = '1; hist2 = '1;
        m_pend = '0; m_svc = 2'b00;
        m_busy = 0; m_pri = 0; m_src = 0;
    endtask

    // Advance the model by one rising edge using the current inputs
    task automatic model_step();
        int            cur;
        int            best, best_rank, lvl, rank;
        logic [NS-1:0] elig, pend_n;
        logic [1:0]    svc_n;
        bit            ack_hit;
        cur     = m_svc[1] ? 2 : (m_svc[0] ? 1 : 0);
        elig    = m_pend & cfg_en & {NS{glob_en}};
        ack_hit = m_busy && int_ack;

        svc_n = m_svc;
        if (reti) begin
            if (m_svc[1])      svc_n[1] = 1'b0;
            else if (m_svc[0]) svc_n[0] = 1'b0;
        end
        if (ack_hit) svc_n[m_pri ? 1 : 0] = 1'b1;

        // hist1/hist2 are the pin as seen two and three edges back
        for (int i = 0; i < NS; i++) begin
            if (cfg_edge[i])
                pend_n[i] = (hist2[i] && !hist1[i]) || (m_pend[i] && !(ack_hit && m_src == i));
            else
                pend_n[i] = !hist1[i];
        end

        if (m_busy) begin
            if (ack_hit || !elig[m_src]) m_busy = 0;
        end else begin
            best = -1;
            best_rank = -1;
            for (int i = 0; i < NS; i++) begin
                lvl = cfg_pri[i] ? 2 : 1;
                rank = lvl * 16 + (15 - i);
                if (elig[i] && lvl > cur && rank > best_rank) begin
                    best_rank = rank;
                    best = i;
                end
            end
            if (best >= 0) begin
                m_busy = 1;
                m_src  = best;
                m_pri  = cfg_pri[best];
            end
        end

        hist2 = hist1;
        hist1 = hist0;
        hist0 = int_n;
        m_svc  = svc_n;
        m_pend = pend_n;
    endtask

    task automatic compare_outputs();
        logic [7:0] exp_vec;
        exp_vec = 8'(8'h03 + m_src * 8);
        check("int_req", 32'(int_req), 32'(m_busy));
        if (m_busy) begin
            check("int_src", 32'(int_src), 32'(m_src));
            check("int_vec", 32'(int_vec), 32'(exp_vec));
        end
        check("in_svc", 32'(in_svc), 32'(m_svc));
        check("int_act", 32'(int_act), 32'(|m_svc));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req"}, 32'(int_req), 32'd0);
        check({pfx, "_src"}, 32'(int_src), 32'd0);
        check({pfx, "_vec"}, 32'(int_vec), 32'd0);
        check({pfx, "_act"}, 32'(int_act), 32'd0);
        check({pfx, "_svc"}, 32'(in_svc),  32'd0);
    endtask

    initial begin
        bit did_rst;
        did_rst  = 0;
        rst      = 1'b0;
        int_n    = '1;
        cfg_en   = '1;
        cfg_pri  = '0;
        cfg_edge = '1;
        glob_en  = 1'b1;
        int_ack  = 1'b0;
        reti     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // Asynchronous reset mid-request with something in service
            if (!did_rst && ((cyc >= 1500 && m_busy && m_svc != 2'b00) || cyc == 2200)) begin
                rst     = 1'b0;
                int_n   = '1;
                int_ack = 1'b0;
                reti    = 1'b0;
                #1 check_all_zero("async_rst");
                model_reset();
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                did_rst = 1;
            end

            for (int i = 0; i < NS; i++)
                if ($urandom_range(7) == 0) int_n[i] = ~int_n[i];
            if (cyc % 64 == 0) begin
                cfg_en   = NS'($urandom | $urandom);
                cfg_pri  = NS'($urandom);
                cfg_edge = NS'($urandom);
                glob_en  = ($urandom_range(5) != 0);
            end
            int_ack = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            reti    = ($urandom_range(5) == 0);

            @(posedge clk);
            model_step();
            #1 compare_outputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/oc8051_ext_int_ctrl.md
Name: oc8051_ext_int_ctrl

Overview:
External-interrupt controller for the 8051 FPGA top. It synchronises the active-low board interrupt pins (int1..int3), detects edges or levels per source, and arbitrates the pending sources by two-level priority. It issues one vectored request at a time to the core with a req/ack handshake, and tracks in-service nesting until RETI. It drives the board-level int_act indicator.

Parameters:
NUM_SRC, 3, number of external interrupt sources (1..8)
VEC_BASE, 8'h03, vector address of source 0
VEC_STEP, 8'h08, vector address spacing between sources

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
int_n  in  NUM_SRC  raw external interrupt pins, active-low, asynchronous
cfg_en  in  NUM_SRC  per-source enable
cfg_pri  in  NUM_SRC  per-source priority, 1 = high, 0 = low
cfg_edge  in  NUM_SRC  1 = falling-edge triggered, 0 = low-level triggered
glob_en  in  1  global enable (EA)
int_ack  in  1  one-cycle pulse from core: current request accepted
reti  in  1  one-cycle pulse from core: RETI executed
int_req  out  1  vectored request to core
int_src  out  3  index of requesting source
int_vec  out  8  vector address = VEC_BASE + int_src*VEC_STEP (mod 256)
int_act  out  1  any interrupt in service
in_svc  out  2  in-service flags {high, low}

Behaviour:
- Reset (rst low, async): sync flops = all 1; pending = 0; in_svc = 0; int_req = 0; int_src = 0; int_vec = 8'h00; int_act = 0; FSM = IDLE. A reset asserted mid-request or mid-service drops everything immediately.
- Sync: two-flop synchroniser per pin (s1, s2), plus a delay flop s3.
- Edge mode: pending[i] is set on s3 = 1 and s2 = 0. It is cleared only by int_ack while int_src = i. A new edge in the same cycle as the clearing ack re-sets pending (set wins).
- Level mode: pending[i] is registered as ~s2 each cycle. Ack has no effect on it.
- Latency: int_n sampled low at edge N, pending at edge N+2, int_req high after edge N+3.
- eligible[i] = pending[i] & cfg_en[i] & glob_en.
- Current level: 2 if in_svc[1], else 1 if in_svc[0], else 0. A source may request only if its level (high = 2, low = 1) is greater than the current level.
- Arbitration: a high-priority eligible source beats a low-priority one. Within a level, the lowest index wins.
- FSM IDLE:
  - If any requestable source exists, latch the winner into int_src/int_vec, set int_req = 1 next cycle, and go to REQ.
- FSM REQ:
  - int_src and int_vec are held stable; a newly arriving higher-priority source does not replace the winner.
  - int_ack: set the in_svc bit for the winner's priority, clear its edge pending, int_req = 0 next cycle, go to IDLE.
  - Winner no longer eligible (level released, cfg_en or glob_en cleared) without ack: withdraw, int_req = 0 next cycle, go to IDLE.
  - If withdraw and ack occur in the same cycle, ack wins.
- int_ack in IDLE: ignored.
- reti: clears the highest set in_svc bit (high before low). Ignored when in_svc = 0.
- reti and int_ack in the same cycle: reti clears based on the pre-cycle in_svc, then ack sets the new bit. Both apply.
- int_act = |in_svc, registered with in_svc.
- After ack, a new request may be issued no earlier than 1 cycle after int_req falls (IDLE re-arbitration).

Test Plan:
- Edge, low priority, src1: pulse int_n[1] low 10 cycles → int_req after 3 edges, int_src = 1, int_vec = 8'h0B; ack → in_svc = 01, int_act = 1; no re-request; reti → in_svc = 00, int_act = 0.
- Nesting: src0 low in service; src2 high edge → int_req, int_vec = 8'h13; ack → in_svc = 11. A second low-priority edge is not requested until both retis; first reti → in_svc = 01.
- Same level: src0 and src2 both low priority, edges on the same cycle → src0 first; after its ack + reti, src2 is requested (vec 8'h13).
- Level mode, src1 held low: ack → pending persists; after reti the request re-issues. Releasing the pin while in REQ → int_req drops, FSM returns to IDLE, no ack needed.
- glob_en = 0 with edges on all pins → no int_req; set glob_en = 1 → lowest-index high-priority source requested; latched edges are not lost.
- Assert rst low while in REQ with in_svc = 10 → all outputs 0 asynchronously; after release, no request until a new edge arrives.
